// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder around a single 1-bit full-adder cell.
// Operands are captured on an accepted start and fed to the FA LSB first, one
// bit pair per clock. The FA carry lives in a flop between bits, and the Sum
// bits are shifted into a parallel result. The result is published with a
// one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // 1-bit full adder cell: returns {carry_out, sum}
  function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic c);
    fa_cell = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       fa_s;

  // Next-state logic: capture in IDLE, one FA bit per cycle in RUN, publish on the last bit
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    fa_s    = fa_cell(a_sh_q[0], b_sh_q[0], carry_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          s_sh_d  = {WIDTH{1'b0}};
          carry_d = cin;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d = fa_s[1];
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        s_sh_d  = {fa_s[0], s_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last bit: the final Sum bit and carry complete the result
          sum_d   = {fa_s[0], s_sh_q[WIDTH-1:1]};
          cout_d  = fa_s[1];
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // start is ignored here; it is only sampled back in IDLE
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      s_sh_q  <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of the bit-serial adder (WIDTH=8).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: start at edge E0, done must be visible right after E8
  // (the 9th edge counting E0), busy for the 8 samples before that.
  // pulse_at > 0 re-pulses start with FF/FF operands after that many RUN edges.
  task automatic do_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input int pulse_at, input logic [W:0] exp);
    logic [W:0] prev;
    int n;
    int busy_n;
    int extra;
    bit got;
    bit stable;
    prev = {cout, sum};
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;   // operands may change after capture
    n = 0; busy_n = 0; got = 1'b0; stable = 1'b1;
    while (n < 20 && !got) begin
      if (busy) busy_n++;
      if ({cout, sum} !== prev) stable = 1'b0;
      if (pulse_at > 0 && n == pulse_at) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, n, W);
    chk({tag, "_busy_cycles"}, busy_n, W);
    chk({tag, "_hold"}, {31'd0, stable}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_result"}, {23'd0, cout, sum}, {23'd0, exp});
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk({tag, "_single_done"}, extra, 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int k;
    int extra;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   rexp;

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {23'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: zero operands
    do_op("t1_zero", 8'h00, 8'h00, 1'b0, 0, 9'h000);
    // 2: full carry ripple cases
    do_op("t2_ff01", 8'hFF, 8'h01, 1'b0, 0, 9'h100);
    do_op("t2_a55a", 8'hA5, 8'h5A, 1'b1, 0, 9'h100);
    // 3: start re-pulsed in RUN is ignored
    do_op("t3_ignore", 8'h3C, 8'h42, 1'b0, 3, 9'h07E);

    // 4: reset in the middle of an operation
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #3;
    chk("t4_busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", {31'd0, busy}, 32'd0);
    chk("t4_rst_done", {31'd0, done}, 32'd0);
    chk("t4_rst_result", {23'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("t4_no_done", extra, 32'd0);
    do_op("t4_after", 8'h80, 8'h80, 1'b0, 0, 9'h100);

    // 5: start held high -> back-to-back operations 10 cycles apart
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h7F; b = 8'h01;
    t1 = 0; t2 = 0; k = 0;
    while (k < 40 && t1 == 0) begin
      @(posedge clk); #1; k++;
      if (done) t1 = k;
    end
    chk("t5_first_result", {23'd0, cout, sum}, 32'h002);
    while (k < 40 && t2 == 0) begin
      @(posedge clk); #1; k++;
      if (done) t2 = k;
    end
    start = 1'b0;
    chk("t5_second_result", {23'd0, cout, sum}, 32'h080);
    chk("t5_spacing", t2 - t1, 32'd10);
    for (int i = 0; i < 12; i++) @(posedge clk);
    #1;

    // 6: random operands against the reference sum
    for (int i = 0; i < 256; i++) begin
      ra = W'($urandom_range(255, 0));
      rb = W'($urandom_range(255, 0));
      rc = 1'($urandom_range(1, 0));
      rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      do_op($sformatf("t6_rand%0d", i), ra, rb, rc, 0, rexp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
